// File: rtl/divradix4.sv
// Sequential signed radix-4 restoring divider: one base-4 quotient digit per clock,
// quotient truncated toward zero, remainder carries the dividend's sign.
module divradix4 #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         busy,
    output logic         flag,
    output logic         div_by_zero
);

    localparam int unsigned NP = N + 2;
    localparam int unsigned ND = N / 2;
    localparam int unsigned CW = $clog2(ND + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state;
    logic [N-1:0]    a;
    logic [N-1:0]    d;
    logic [NP-1:0]   d3;
    logic [NP-1:0]   p;
    logic [N-1:0]    q;
    logic [CW-1:0]   cnt;
    logic            sign_q;
    logic            sign_r;
    logic            dz;

    logic [N-1:0]    dvd_abs;
    logic [N-1:0]    dvs_abs;
    logic [NP-1:0]   d1;
    logic [NP-1:0]   d2;
    logic [NP-1:0]   pp;
    logic [NP-1:0]   rem;
    logic [1:0]      dig;

    // Operand magnitudes as unsigned, so the most negative value maps exactly.
    always_comb begin
        dvd_abs = Dividend[N-1] ? N'(-Dividend) : Dividend;
        dvs_abs = Divisor[N-1]  ? N'(-Divisor)  : Divisor;
    end

    // Digit selection against D, 2D and 3D on the shifted partial remainder.
    always_comb begin
        d1  = NP'(d);
        d2  = NP'(d) << 1;
        pp  = (p << 2) | NP'(a[N-1 -: 2]);
        dig = 2'd0;
        rem = pp;
        if (pp >= d3) begin
            dig = 2'd3;
            rem = pp - d3;
        end else if (pp >= d2) begin
            dig = 2'd2;
            rem = pp - d2;
        end else if (pp >= d1) begin
            dig = 2'd1;
            rem = pp - d1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            a           <= '0;
            d           <= '0;
            d3          <= '0;
            p           <= '0;
            q           <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dz          <= 1'b0;
            Quotient    <= '0;
            Remainder   <= '0;
            busy        <= 1'b0;
            flag        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a           <= dvd_abs;
                        d           <= dvs_abs;
                        d3          <= NP'(dvs_abs) + (NP'(dvs_abs) << 1);
                        p           <= '0;
                        q           <= '0;
                        cnt         <= CW'(ND);
                        sign_q      <= Dividend[N-1] ^ Divisor[N-1];
                        sign_r      <= Dividend[N-1];
                        dz          <= (Divisor == '0);
                        flag        <= 1'b0;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state       <= (Divisor == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    a   <= a << 2;
                    p   <= rem;
                    q   <= (q << 2) | N'(dig);
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // With a zero divisor, A still holds |Dividend| unshifted.
                    if (dz) begin
                        Quotient    <= '1;
                        Remainder   <= sign_r ? N'(-a) : a;
                        div_by_zero <= 1'b1;
                    end else begin
                        Quotient    <= sign_q ? N'(-q) : q;
                        Remainder   <= sign_r ? N'(-p[N-1:0]) : p[N-1:0];
                        div_by_zero <= 1'b0;
                    end
                    busy  <= 1'b0;
                    flag  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
